tile_buffer_writer: RTL and testbench
=====================================

// Module: tile_buffer_writer
// PURPOSE
//  Write-side client of the board tile RAM (simple dual-port, dual-clock, registered read).
//  Accepts cell-update requests (row, col, tile code) over valid/ready, queues them in a small FIFO
//  and drives the RAM write port (one write per clock); also performs full-buffer clear sweeps.
//  Sits between game logic and the tile RAM write port; runs in the RAM write-clock domain.
// PARAMETERS
//  DATA_WIDTH   7   tile code width; equals RAM data width
//  ROW_W        4   row index width
//  COL_W        5   column index width; RAM address = {row, col}, ADDR_WIDTH = ROW_W+COL_W (9)
//  FIFO_DEPTH   4   request queue entries; power of 2, >= 2
//  CLEAR_VALUE  0   tile code written by the post-reset clear (macro feature only)
// PORTS
//  clk_i          in   1           single clock; connect to the RAM write clock
//  rst_i          in   1           asynchronous, active-high reset
//  req_valid_i    in   1           update request valid
//  req_ready_o    out  1           queue can accept; equals !fifo_full (combinational from count)
//  req_row_i      in   ROW_W       target row
//  req_col_i      in   COL_W       target column
//  req_data_i     in   DATA_WIDTH  tile code to write
//  clear_i        in   1           1-cycle pulse: start clear sweep
//  clear_data_i   in   DATA_WIDTH  fill code, sampled when clear_i is high
//  busy_o         out  1           state==CLEAR | fifo non-empty | ram_we_o
//  done_o         out  1           1-cycle pulse, cycle after last clear write
//  ram_we_o       out  1           RAM write enable (registered)
//  ram_addr_o     out  ROW_W+COL_W RAM write address (registered)
//  ram_data_o     out  DATA_WIDTH  RAM write data (registered)
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, clear_pend 0; ram_we_o/ram_addr_o/ram_data_o/done_o = 0;
//    busy_o 0; req_ready_o 1. Reset mid-sweep or mid-queue discards all pending work.
//  - Push: at posedge with req_valid_i & req_ready_o, {row,col,data} enters FIFO. Pushes allowed in
//    every state. Push and pop in the same cycle: count unchanged. No push when full.
//  - clear_i latches clear_data_i and sets clear_pend; a later clear_i overwrites the latched code.
//  - FSM IDLE: clear_pend -> CLEAR (sweep addr 0, clear_pend cleared); clear wins over FIFO.
//    Else if FIFO non-empty: pop head; same edge registers ram_we_o=1, addr={row,col}, data.
//    Else ram_we_o=0.
//  - FSM CLEAR: one write per cycle, addr 0..2^ADDR_WIDTH-1 ascending, data = latched fill code.
//    After writing the last address -> IDLE, done_o=1 for one cycle. FIFO is not popped in CLEAR;
//    queued updates are written after the sweep and so survive the clear.
//    clear_i during CLEAR: restart at addr 0 with the new fill code; done_o only at end of final sweep.
//  - Latency: request accepted at edge N into empty FIFO in IDLE -> popped at edge N+1 ->
//    ram_we_o high in cycle after N+1. Sustained throughput 1 write/cycle.
//  - Address wrap: sweep counter is ADDR_WIDTH+1 bits; terminal detect on all-ones address, no wrap.
//  - FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  TILE_WRITER_CLEAR_ON_RESET_EN defined: reset places FSM in CLEAR with addr 0 and fill code
//    CLEAR_VALUE; busy_o=1 out of reset; done_o pulses after address 2^ADDR_WIDTH-1 is written.
//  Not defined: reset enters IDLE; RAM contents untouched until clear_i or requests.
// TESTING
//  1. Reset, push (row 2,col 3,data 7'h15) -> ram_we_o=1, addr 9'h043, data 7'h15 two cycles after accept.
//  2. Hold req_valid_i with ram side busy in CLEAR: 4 pushes -> req_ready_o=0; 5th held until sweep ends,
//     then 4 queued writes appear in push order on consecutive cycles.
//  3. clear_i with clear_data_i=7'h7F -> 512 consecutive writes addr 0..511 of 7'h7F, done_o one cycle.
//  4. clear_i again at sweep addr 100 with 7'h01 -> sweep restarts at 0 with 7'h01; one done_o total.
//  5. Assert rst_i mid-sweep (addr 200) -> ram_we_o=0, busy_o=0, FIFO empty; no writes after release.
//  6. With TILE_WRITER_CLEAR_ON_RESET_EN: release reset -> 512 writes of CLEAR_VALUE, then done_o.

Source files
------------

// File: rtl/tile_buffer_writer.sv
// Tile RAM write-port client: queues (row, col, code) updates and performs full-buffer clear sweeps.
// Optional TILE_WRITER_CLEAR_ON_RESET_EN: reset starts a clear sweep filled with CLEAR_VALUE.
module tile_buffer_writer #(
  parameter int DATA_WIDTH = 7,
  parameter int ROW_W = 4,
  parameter int COL_W = 5,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [ROW_W-1:0]       req_row_i,
  input  logic [COL_W-1:0]       req_col_i,
  input  logic [DATA_WIDTH-1:0]  req_data_i,
  input  logic                   clear_i,
  input  logic [DATA_WIDTH-1:0]  clear_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ram_we_o,
  output logic [ROW_W+COL_W-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]  ram_data_o
);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = ADDR_W + DATA_WIDTH;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
  localparam logic [0:0]            RST_STATE = ST_CLEAR;
  localparam logic [DATA_WIDTH-1:0] RST_FILL  = CLEAR_VALUE;
`else
  localparam logic [0:0]            RST_STATE = ST_IDLE;
  localparam logic [DATA_WIDTH-1:0] RST_FILL  = '0;
`endif

  logic [0:0]            state_q, state_d;
  logic [ADDR_W:0]       sweep_q, sweep_d;
  logic                  clear_pend_q, clear_pend_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  done_q, done_d;
  logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_empty  = (count_q == '0);
  assign req_ready_o = (count_q != FULL_CNT);
  assign push        = req_valid_i & req_ready_o;
  assign busy_o      = (state_q == ST_CLEAR) | ~fifo_empty | ram_we_q;
  assign done_o      = done_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;

  // The sweep counter's top bit is set only by the terminal write; it marks the done pulse.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    clear_pend_d = clear_pend_q;
    fill_d       = clear_i ? clear_data_i : fill_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    done_d       = 1'b0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        done_d          = sweep_q[ADDR_W];
        sweep_d[ADDR_W] = 1'b0;
        if (clear_pend_q) begin
          state_d      = ST_CLEAR;
          sweep_d      = '0;
          clear_pend_d = 1'b0;
        end else begin
          if (clear_i) clear_pend_d = 1'b1;
          if (!fifo_empty) begin
            pop                      = 1'b1;
            ram_we_d                 = 1'b1;
            {ram_addr_d, ram_data_d} = fifo_mem_q[rd_ptr_q];
          end
        end
      end
      default: begin
        // A new clear during a sweep restarts from address 0 with the new fill code.
        if (clear_i) begin
          sweep_d = '0;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = sweep_q[ADDR_W-1:0];
          ram_data_d = fill_q;
          sweep_d    = sweep_q + 1'b1;
          if (&sweep_q[ADDR_W-1:0]) state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RST_STATE;
      sweep_q      <= '0;
      clear_pend_q <= 1'b0;
      fill_q       <= RST_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      clear_pend_q <= clear_pend_d;
      fill_q       <= fill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      done_q       <= done_d;
    end
  end

  // Queue storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {req_row_i, req_col_i, req_data_i};
  end

endmodule

// File: tb/tb_tile_buffer_writer.sv
// Bench for tile_buffer_writer: expected RAM write stream kept as a queue, checked every cycle.
module tb_tile_buffer_writer;
  localparam int DW = 7;
  localparam int RW = 4;
  localparam int CW = 5;
  localparam int AW = RW + CW;
  localparam int NCELL = 1 << AW;
  localparam logic [DW-1:0] CLR_VAL = 7'h3C;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [RW-1:0] req_row_i = '0;
  logic [CW-1:0] req_col_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic          clear_i = 1'b0;
  logic [DW-1:0] clear_data_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o;

  tile_buffer_writer #(
    .DATA_WIDTH(DW), .ROW_W(RW), .COL_W(CW), .FIFO_DEPTH(4), .CLEAR_VALUE(CLR_VAL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_row_i(req_row_i), .req_col_i(req_col_i), .req_data_i(req_data_i),
    .clear_i(clear_i), .clear_data_i(clear_data_i),
    .busy_o(busy_o), .done_o(done_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Each entry: {last_of_sweep, addr, data}; a sweep's final entry must be followed by done_o.
  logic [AW+DW:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_writes = 0;
  int done_cnt = 0;
  logic done_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    logic [AW+DW:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        done_exp = 1'b0;
      end else begin
        check("done_timing", done_o, done_exp);
        if (done_o) done_cnt++;
        done_exp = 1'b0;
        if (ram_we_o) begin
          n_writes++;
          if (exp_q.size() == 0) begin
            check("spurious_we", ram_we_o, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("write", {ram_addr_o, ram_data_o}, e[AW+DW-1:0]);
            done_exp = e[AW+DW];
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sweep(input logic [DW-1:0] d);
    for (int a = 0; a < NCELL; a++) exp_q.push_back({(a == NCELL-1), AW'(a), d});
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done_o && k < 3000) begin
      @(posedge clk_i); #1;
      k++;
    end
    check(name, done_o, 1'b1);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    clear_i = 1'b0;
    repeat (3) @(posedge clk_i);
    exp_q.delete();
    @(negedge clk_i);
    check("rst_we", ram_we_o, 1'b0);
    check("rst_addr", ram_addr_o, '0);
    check("rst_data", ram_data_o, '0);
    check("rst_done", done_o, 1'b0);
    check("rst_ready", req_ready_o, 1'b1);
`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
    check("rst_busy", busy_o, 1'b1);
    push_sweep(CLR_VAL);
`else
    check("rst_busy", busy_o, 1'b0);
`endif
    rst_i = 1'b0;
    @(posedge clk_i); #1;
`ifdef TILE_WRITER_CLEAR_ON_RESET_EN
    wait_done("rst_sweep_done");
    repeat (3) begin @(posedge clk_i); #1; end
    check("rst_sweep_drained", exp_q.size(), 0);
`endif
  endtask

  task automatic push_req(input logic [RW-1:0] r, input logic [CW-1:0] c, input logic [DW-1:0] d);
    int k = 0;
    req_valid_i = 1'b1;
    req_row_i = r;
    req_col_i = c;
    req_data_i = d;
    while (!req_ready_o && k < 2000) begin
      @(posedge clk_i); #1;
      k++;
    end
    check("push_ready", req_ready_o, 1'b1);
    exp_q.push_back({1'b0, r, c, d});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_clear(input logic [DW-1:0] d);
    clear_i = 1'b1;
    clear_data_i = d;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, output bit found);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk_i);
      if (ram_we_o && ram_addr_o == a) found = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int d0;
    int k;
    bit found;

    apply_reset();

    // Single request: accepted at edge N, write visible after edge N+1.
    req_valid_i = 1'b1;
    req_row_i = 4'd2;
    req_col_i = 5'd3;
    req_data_i = 7'h15;
    check("t1_ready", req_ready_o, 1'b1);
    exp_q.push_back({1'b0, 4'd2, 5'd3, 7'h15});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("t1_we_after_accept", ram_we_o, 1'b0);
    @(posedge clk_i); #1;
    check("t1_write", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 9'h043, 7'h15});
    @(posedge clk_i); #1;
    check("t1_we_drop", ram_we_o, 1'b0);
    repeat (2) begin @(posedge clk_i); #1; end
    check("t1_idle_busy", busy_o, 1'b0);

    // Queue fills behind a sweep; the fifth request waits for the sweep to finish.
    do_clear(7'h2A);
    push_sweep(7'h2A);
    repeat (5) begin @(posedge clk_i); #1; end
    check("t2_busy", busy_o, 1'b1);
    push_req(4'd1, 5'd2, 7'h11);
    push_req(4'd3, 5'd4, 7'h22);
    push_req(4'd5, 5'd6, 7'h33);
    push_req(4'd7, 5'd8, 7'h44);
    check("t2_full", req_ready_o, 1'b0);
    req_valid_i = 1'b1;
    req_row_i = 4'd9;
    req_col_i = 5'd10;
    req_data_i = 7'h55;
    k = 0;
    while (!req_ready_o && k < 2000) begin
      @(posedge clk_i); #1;
      k++;
    end
    check("t2_ready_after_sweep", req_ready_o, 1'b1);
    check("t2_q0", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 4'd1, 5'd2, 7'h11});
    exp_q.push_back({1'b0, 4'd9, 5'd10, 7'h55});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("t2_q1", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 4'd3, 5'd4, 7'h22});
    @(posedge clk_i); #1;
    check("t2_q2", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 4'd5, 5'd6, 7'h33});
    @(posedge clk_i); #1;
    check("t2_q3", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 4'd7, 5'd8, 7'h44});
    @(posedge clk_i); #1;
    check("t2_q4", {ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 4'd9, 5'd10, 7'h55});
    repeat (3) begin @(posedge clk_i); #1; end
    check("t2_drained", exp_q.size(), 0);

    // Full sweep of 7'h7F: 512 writes then one done pulse.
    w0 = n_writes;
    d0 = done_cnt;
    do_clear(7'h7F);
    push_sweep(7'h7F);
    repeat (4) begin @(posedge clk_i); #1; end
    check("t3_busy", busy_o, 1'b1);
    wait_done("t3_done");
    repeat (3) begin @(posedge clk_i); #1; end
    check("t3_write_count", n_writes - w0, NCELL);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_idle_busy", busy_o, 1'b0);

    // Restart at address 100 with 7'h01: remaining old writes are abandoned.
    d0 = done_cnt;
    do_clear(7'h33);
    push_sweep(7'h33);
    wait_addr(9'd100, found);
    check("t4_reached_100", found, 1'b1);
    clear_data_i = 7'h01;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    exp_q.delete();
    push_sweep(7'h01);
    wait_done("t4_done");
    repeat (5) begin @(posedge clk_i); #1; end
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_drained", exp_q.size(), 0);

    // Reset mid-sweep with requests queued: all pending work discarded.
    do_clear(7'h44);
    push_sweep(7'h44);
    push_req(4'd4, 5'd4, 7'h66);
    push_req(4'd6, 5'd1, 7'h77);
    wait_addr(9'd200, found);
    check("t5_reached_200", found, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("t5_we", ram_we_o, 1'b0);
    check("t5_ready", req_ready_o, 1'b1);
    check("t5_done", done_o, 1'b0);
    apply_reset();
    repeat (20) begin @(posedge clk_i); #1; end
    check("t5_busy_after", busy_o, 1'b0);
    check("t5_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
